pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Parametrised pipeline controller for the openmips core, replacing the fixed six-bit stall generator. It takes per-stage stall requests, a redirect (flush) request and a halt/resume handshake. It drives the per-stage stall vector, per-stage flush strobes, a redirect PC to pc_reg, and a stall watchdog. It sits beside the pipeline registers; every pc_reg/if_id/id_ex/ex_mem/mem_wb instance consumes its outputs.

## Interface
- STAGES, 6, pipeline positions; index 0 = PC, 1 = IF/ID, …, STAGES-1 = WB (minimum 4)
- FLUSH_STAGE, 2, highest position cleared by a redirect (1 ≤ FLUSH_STAGE < STAGES-1)
- AW, 32, redirect PC width
- CW, 8, stall counter width
- MAX_STALL, 200, consecutive stalled cycles that trip the watchdog (must be < 2^CW)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- stallreq_i  in  STAGES  bit k = stage k requests a hold
- flush_req_i  in  1  redirect request (branch/exception resolved)
- flush_pc_i  in  AW  redirect target, sampled with flush_req_i
- halt_req_i  in  1  level; request drain-and-halt
- resume_i  in  1  single-cycle pulse; leave HALTED
- stall_o  out  STAGES  bit k = 1 holds position k
- flush_o  out  STAGES  bit k = 1 clears pipeline register k this cycle
- new_pc_o  out  AW  redirect target
- new_pc_valid_o  out  1  load new_pc_o into PC this cycle
- halted_o  out  1  pipeline empty and frozen
- stall_cnt_o  out  CW  consecutive stalled cycles, saturating
- watchdog_o  out  1  sticky stall-timeout flag

## Operation
- Stall encoding:
  - h = highest set index of stallreq_i.
  - stall_o[j] = 1 for all j ≤ h; all other bits are 0.
  - stall_o is combinational from stallreq_i and state.
  - A bubble is implied at h+1 by the existing rule: a register whose bit is 0 while the bit below is 1 loads a bubble.
- States: RUN, FLUSH, DRAIN, HALTED.
- RUN:
  - stall_o follows the stall encoding.
  - flush_req_i → FLUSH. The next edge registers flush_pc_i.
  - If flush_req_i is low and halt_req_i is high → DRAIN. drain_cnt is loaded with STAGES-2.
- FLUSH (exactly one cycle):
  - flush_o[k] = 1 for 1 ≤ k ≤ FLUSH_STAGE; new_pc_valid_o = 1; stall_o = 0. Stall requests are ignored this cycle.
  - Next state is RUN. A new flush_req_i in this cycle re-enters FLUSH with the new PC.
- DRAIN:
  - stall_o = OR of 2'b11 and the stall encoding, so PC and IF/ID are held and bubbles enter ID.
  - drain_cnt decrements only in cycles where stallreq_i[STAGES-1:2] == 0.
  - drain_cnt == 0 in a non-stalled cycle → HALTED.
  - halt_req_i deasserting → RUN, and the count is discarded.
- HALTED:
  - stall_o = all ones; halted_o = 1.
  - resume_i → RUN on the next edge.
- Flush has priority over everything in every state. flush_req_i in DRAIN or HALTED → FLUSH, and the halt is abandoned. The halt re-arms only if halt_req_i is still high once the block is back in RUN.
- Watchdog:
  - stall_cnt_o increments each cycle stallreq_i != 0 in RUN or DRAIN.
  - It clears in any cycle with no request, and in FLUSH or HALTED.
  - It saturates at 2^CW-1.
  - watchdog_o is set on the edge where stall_cnt_o reaches MAX_STALL. It is cleared only by reset or by a FLUSH cycle.
- new_pc_o holds its last captured value between flushes.

## Timing
- Reset (rst = 0, asynchronous):
  - state = RUN.
  - stall_o, flush_o, new_pc_o and stall_cnt_o are 0; new_pc_valid_o, halted_o and watchdog_o are 0.
  - drain_cnt = 0.
- Reset mid-FLUSH or mid-DRAIN aborts immediately with no pending redirect.
- Latency:
  - Stall: 0 cycles (same-cycle combinational).
  - Redirect: flush_req_i at edge N → flush_o and new_pc_valid_o high for cycle N+1 only.
- A halt takes at least STAGES-1 cycles from halt_req_i to halted_o. Each cycle a downstream stall request blocks adds one cycle.
- Resume: resume_i in cycle N → halted_o = 0 and stall_o = encoding in cycle N+1.
- Simultaneous flush_req_i and halt_req_i in RUN: flush is taken; halt is evaluated afterwards.

## Test plan
- STAGES = 6, stallreq_i = 6'b001000 → stall_o = 6'b001111, flush_o = 0. Then stallreq_i = 6'b000100 → stall_o = 6'b000111 in the same cycle.
- flush_req_i = 1 with flush_pc_i = 0x0000_0100 for one cycle, stallreq_i = 6'b010000 → next cycle: flush_o = 6'b000110, new_pc_valid_o = 1, new_pc_o = 0x100, stall_o = 0. The cycle after: stall_o = 6'b011111.
- halt_req_i held, no stalls → halted_o rises exactly 5 cycles later. Repeat with stallreq_i[3] high for 3 of those cycles → halted_o rises 8 cycles later. resume_i → halted_o = 0 one cycle later.
- Assert flush_req_i while HALTED → one FLUSH cycle, then RUN, halted_o = 0. With halt_req_i still high, DRAIN restarts.
- stallreq_i = 6'b000100 held for 200 cycles → watchdog_o = 1 on the 200th edge. With CW = 8, stall_cnt_o saturates at 255. A flush clears both.
- Drop rst mid-DRAIN with a flush pending → all outputs 0 immediately. After release, state is RUN and no new_pc_valid_o pulse appears.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the pipeline controller and the core:
// stall/flush/halt requests in, per-stage hold and clear controls out.
interface pipe_ctrl_if #(
    parameter int STAGES = 6,
    parameter int AW     = 32,
    parameter int CW     = 8
);
    logic [STAGES-1:0] stallreq_i;
    logic              flush_req_i;
    logic [AW-1:0]     flush_pc_i;
    logic              halt_req_i;
    logic              resume_i;
    logic [STAGES-1:0] stall_o;
    logic [STAGES-1:0] flush_o;
    logic [AW-1:0]     new_pc_o;
    logic              new_pc_valid_o;
    logic              halted_o;
    logic [CW-1:0]     stall_cnt_o;
    logic              watchdog_o;

    modport master (
        output stallreq_i, flush_req_i, flush_pc_i, halt_req_i, resume_i,
        input  stall_o, flush_o, new_pc_o, new_pc_valid_o, halted_o,
               stall_cnt_o, watchdog_o
    );

    modport slave (
        input  stallreq_i, flush_req_i, flush_pc_i, halt_req_i, resume_i,
        output stall_o, flush_o, new_pc_o, new_pc_valid_o, halted_o,
               stall_cnt_o, watchdog_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall smearing, redirect flush, drain-and-halt
// sequencing and a saturating stall watchdog for the openmips pipeline.

// One pipeline position: extends the stall chain from the stage above and
// decodes this position's hold and clear controls from the shared mode.
module pipe_ctrl_stage #(
    parameter int IDX         = 0,
    parameter int FLUSH_STAGE = 2
) (
    input  logic req,
    input  logic above,
    input  logic use_enc,
    input  logic hold_front,
    input  logic hold_all,
    input  logic flush_cyc,
    output logic enc,
    output logic stall,
    output logic flush
);
    localparam logic FRONT   = (IDX < 2);
    localparam logic CLEARED = (IDX >= 1) && (IDX <= FLUSH_STAGE);

    assign enc   = req | above;
    assign stall = hold_all | (use_enc & enc) | (hold_front & FRONT);
    assign flush = flush_cyc & CLEARED;
endmodule

module pipe_ctrl #(
    parameter int STAGES      = 6,
    parameter int FLUSH_STAGE = 2,
    parameter int AW          = 32,
    parameter int CW          = 8,
    parameter int MAX_STALL   = 200
) (
    input logic       clk,
    input logic       rst,
    pipe_ctrl_if.slave bus
);
    localparam int DW = $clog2(STAGES);

    typedef enum logic [1:0] {RUN, FLUSH, DRAIN, HALTED} state_t;

    state_t         state, state_nxt;
    logic [DW-1:0]  drain_cnt, drain_nxt;
    logic [AW-1:0]  new_pc;
    logic [CW-1:0]  stall_cnt, cnt_nxt;
    logic           wd;
    logic           down_stall;
    logic           busy;
    logic [STAGES:0] chain;

    assign down_stall = |bus.stallreq_i[STAGES-1:2];
    assign busy       = (|bus.stallreq_i) && (state == RUN || state == DRAIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            drain_cnt <= '0;
            new_pc    <= '0;
            stall_cnt <= '0;
            wd        <= 1'b0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_nxt;
            stall_cnt <= cnt_nxt;
            // Every accepted redirect lands in FLUSH, so capture unconditionally.
            if (bus.flush_req_i)
                new_pc <= bus.flush_pc_i;
            if (state == FLUSH)
                wd <= 1'b0;
            else if (busy && cnt_nxt == CW'(MAX_STALL))
                wd <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        drain_nxt = drain_cnt;
        case (state)
            RUN: begin
                if (bus.flush_req_i) begin
                    state_nxt = FLUSH;
                end else if (bus.halt_req_i) begin
                    state_nxt = DRAIN;
                    drain_nxt = DW'(STAGES - 2);
                end
            end
            FLUSH: begin
                state_nxt = bus.flush_req_i ? FLUSH : RUN;
            end
            DRAIN: begin
                if (bus.flush_req_i) begin
                    state_nxt = FLUSH;
                    drain_nxt = '0;
                end else if (!bus.halt_req_i) begin
                    state_nxt = RUN;
                    drain_nxt = '0;
                end else if (!down_stall) begin
                    // Count reaches zero on the edge that enters HALTED.
                    if (drain_cnt <= DW'(1)) begin
                        state_nxt = HALTED;
                        drain_nxt = '0;
                    end else begin
                        drain_nxt = drain_cnt - DW'(1);
                    end
                end
            end
            HALTED: begin
                if (bus.flush_req_i)
                    state_nxt = FLUSH;
                else if (bus.resume_i)
                    state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        cnt_nxt = '0;
        if (busy)
            cnt_nxt = (&stall_cnt) ? stall_cnt : stall_cnt + CW'(1);
    end

    assign chain[STAGES] = 1'b0;

    // Holds are gated by rst so every control is low while in reset.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_ctrl_stage #(
            .IDX         (k),
            .FLUSH_STAGE (FLUSH_STAGE)
        ) u_stage (
            .req        (bus.stallreq_i[k]),
            .above      (chain[k+1]),
            .use_enc    (rst && (state == RUN || state == DRAIN)),
            .hold_front (rst && state == DRAIN),
            .hold_all   (rst && state == HALTED),
            .flush_cyc  (state == FLUSH),
            .enc        (chain[k]),
            .stall      (bus.stall_o[k]),
            .flush      (bus.flush_o[k])
        );
    end

    assign bus.new_pc_o       = new_pc;
    assign bus.new_pc_valid_o = (state == FLUSH);
    assign bus.halted_o       = (state == HALTED);
    assign bus.stall_cnt_o    = stall_cnt;
    assign bus.watchdog_o     = wd;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus queues hand-computed expectations
// per cycle, a negedge monitor pops and compares them against the outputs.
module tb_pipe_ctrl;
    localparam logic [6:0] M_ST  = 7'h01;
    localparam logic [6:0] M_FL  = 7'h02;
    localparam logic [6:0] M_PC  = 7'h04;
    localparam logic [6:0] M_PV  = 7'h08;
    localparam logic [6:0] M_HA  = 7'h10;
    localparam logic [6:0] M_CN  = 7'h20;
    localparam logic [6:0] M_WD  = 7'h40;
    localparam logic [6:0] M_ALL = 7'h7f;

    typedef struct {
        int          due;
        string       name;
        logic [6:0]  m;
        logic [5:0]  stall;
        logic [5:0]  flush;
        logic [31:0] pc;
        logic        pcv;
        logic        halted;
        logic [7:0]  cnt;
        logic        wd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];

    pipe_ctrl_if #(.STAGES(6), .AW(32), .CW(8)) bus();

    pipe_ctrl #(
        .STAGES(6), .FLUSH_STAGE(2), .AW(32), .CW(8), .MAX_STALL(200)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [6:0] m,
                       input logic [5:0] stall, input logic [5:0] flush,
                       input logic [31:0] pc, input logic pcv, input logic halted,
                       input logic [7:0] cnt, input logic wd);
        exp_t e;
        e.due = cyc; e.name = name; e.m = m; e.stall = stall; e.flush = flush;
        e.pc = pc; e.pcv = pcv; e.halted = halted; e.cnt = cnt; e.wd = wd;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic ok;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            ok = 1'b1;
            if (e.m[0] && bus.stall_o        !== e.stall)  ok = 1'b0;
            if (e.m[1] && bus.flush_o        !== e.flush)  ok = 1'b0;
            if (e.m[2] && bus.new_pc_o       !== e.pc)     ok = 1'b0;
            if (e.m[3] && bus.new_pc_valid_o !== e.pcv)    ok = 1'b0;
            if (e.m[4] && bus.halted_o       !== e.halted) ok = 1'b0;
            if (e.m[5] && bus.stall_cnt_o    !== e.cnt)    ok = 1'b0;
            if (e.m[6] && bus.watchdog_o     !== e.wd)     ok = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL %s (mask %b): got stall=%b flush=%b pc=%h pcv=%b halted=%b cnt=%0d wd=%b, expected stall=%b flush=%b pc=%h pcv=%b halted=%b cnt=%0d wd=%b",
                         e.name, e.m, bus.stall_o, bus.flush_o, bus.new_pc_o,
                         bus.new_pc_valid_o, bus.halted_o, bus.stall_cnt_o, bus.watchdog_o,
                         e.stall, e.flush, e.pc, e.pcv, e.halted, e.cnt, e.wd);
            end
        end
    end

    initial begin
        logic [5:0] es;
        rst = 1'b0;
        bus.stallreq_i  = 6'b001000;
        bus.flush_req_i = 1'b0;
        bus.flush_pc_i  = '0;
        bus.halt_req_i  = 1'b0;
        bus.resume_i    = 1'b0;

        tick;
        chk("reset", M_ALL, 6'b0, 6'b0, 32'h0, 0, 0, 8'd0, 0);
        tick;
        bus.stallreq_i = 6'b0;
        rst = 1'b1;
        tick;

        // Stall encoding
        bus.stallreq_i = 6'b001000;
        chk("enc_001000", M_ST | M_FL | M_CN, 6'b001111, 6'b0, 32'h0, 0, 0, 8'd0, 0);
        tick;
        bus.stallreq_i = 6'b000100;
        chk("enc_000100", M_ST | M_CN, 6'b000111, 6'b0, 32'h0, 0, 0, 8'd1, 0);
        tick;
        bus.stallreq_i = 6'b0;
        chk("enc_none", M_ST | M_CN, 6'b0, 6'b0, 32'h0, 0, 0, 8'd2, 0);
        tick;
        chk("cnt_clear", M_CN, 6'b0, 6'b0, 32'h0, 0, 0, 8'd0, 0);
        tick;

        // Redirect
        bus.flush_req_i = 1'b1;
        bus.flush_pc_i  = 32'h0000_0100;
        bus.stallreq_i  = 6'b010000;
        chk("flush_req_run", M_ST | M_FL | M_PV, 6'b011111, 6'b0, 32'h0, 0, 0, 8'd0, 0);
        tick;
        bus.flush_req_i = 1'b0;
        chk("flush_cycle", M_ALL, 6'b0, 6'b000110, 32'h100, 1, 0, 8'd1, 0);
        tick;
        chk("after_flush", M_ST | M_FL | M_PC | M_PV | M_CN, 6'b011111, 6'b0, 32'h100, 0, 0, 8'd0, 0);
        tick;
        bus.stallreq_i = 6'b0;
        chk("after_flush2", M_ST | M_CN, 6'b0, 6'b0, 32'h0, 0, 0, 8'd1, 0);
        tick;

        // Clean drain: halted exactly 5 cycles after the request
        bus.halt_req_i = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            es = (i == 0) ? 6'b0 : (i == 5) ? 6'b111111 : 6'b000011;
            chk($sformatf("halt_clean_%0d", i), M_ST | M_HA, es, 6'b0, 32'h0, 0, (i == 5), 8'd0, 0);
            tick;
        end
        bus.halt_req_i = 1'b0;
        bus.resume_i   = 1'b1;
        chk("resume_cycle", M_HA | M_ST, 6'b111111, 6'b0, 32'h0, 0, 1, 8'd0, 0);
        tick;
        bus.resume_i   = 1'b0;
        bus.stallreq_i = 6'b000100;
        chk("resumed", M_HA | M_ST, 6'b000111, 6'b0, 32'h0, 0, 0, 8'd0, 0);
        tick;
        bus.stallreq_i = 6'b0;
        tick;

        // Drain blocked for 3 cycles by a downstream stall
        bus.halt_req_i = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            bus.stallreq_i = (i >= 2 && i <= 4) ? 6'b001000 : 6'b0;
            if (i == 0)                es = 6'b0;
            else if (i == 8)           es = 6'b111111;
            else if (i >= 2 && i <= 4) es = 6'b001111;
            else                       es = 6'b000011;
            chk($sformatf("halt_blocked_%0d", i), M_ST | M_HA, es, 6'b0, 32'h0, 0, (i == 8), 8'd0, 0);
            tick;
        end

        // Flush while halted abandons the halt; still-high request re-arms it
        bus.flush_req_i = 1'b1;
        bus.flush_pc_i  = 32'h0000_0200;
        chk("flush_in_halted", M_ST | M_HA, 6'b111111, 6'b0, 32'h0, 0, 1, 8'd0, 0);
        tick;
        bus.flush_req_i = 1'b0;
        chk("flush_from_halt", M_ST | M_FL | M_PC | M_PV | M_HA, 6'b0, 6'b000110, 32'h200, 1, 0, 8'd0, 0);
        tick;
        chk("run_after_halt_flush", M_ST | M_PV | M_HA, 6'b0, 6'b0, 32'h0, 0, 0, 8'd0, 0);
        tick;
        bus.halt_req_i = 1'b0;
        chk("drain_rearmed", M_ST | M_HA, 6'b000011, 6'b0, 32'h0, 0, 0, 8'd0, 0);
        tick;
        chk("drain_abandoned", M_ST | M_HA, 6'b0, 6'b0, 32'h0, 0, 0, 8'd0, 0);
        tick;

        // Watchdog trip at 200, saturation at 255
        bus.stallreq_i = 6'b000100;
        for (int k = 0; k < 260; k++) begin
            if (k == 199) chk("wd_199", M_CN | M_WD, 6'b0, 6'b0, 32'h0, 0, 0, 8'd199, 0);
            if (k == 200) chk("wd_200", M_CN | M_WD, 6'b0, 6'b0, 32'h0, 0, 0, 8'd200, 1);
            if (k == 255) chk("cnt_255", M_CN | M_WD, 6'b0, 6'b0, 32'h0, 0, 0, 8'd255, 1);
            if (k == 259) chk("cnt_sat", M_CN | M_WD, 6'b0, 6'b0, 32'h0, 0, 0, 8'd255, 1);
            tick;
        end
        bus.flush_req_i = 1'b1;
        bus.flush_pc_i  = 32'h0000_0300;
        chk("wd_pre_flush", M_CN | M_WD, 6'b0, 6'b0, 32'h0, 0, 0, 8'd255, 1);
        tick;
        bus.flush_req_i = 1'b0;
        bus.stallreq_i  = 6'b0;
        chk("wd_flush_cycle", M_PC | M_PV | M_WD, 6'b0, 6'b0, 32'h300, 1, 0, 8'd0, 1);
        tick;
        chk("wd_cleared", M_CN | M_WD, 6'b0, 6'b0, 32'h0, 0, 0, 8'd0, 0);
        tick;

        // Back-to-back redirects re-enter FLUSH with the newer target
        bus.flush_req_i = 1'b1;
        bus.flush_pc_i  = 32'h0000_0500;
        tick;
        bus.flush_pc_i  = 32'h0000_0600;
        chk("flush_again_1", M_FL | M_PC | M_PV, 6'b0, 6'b000110, 32'h500, 1, 0, 8'd0, 0);
        tick;
        bus.flush_req_i = 1'b0;
        chk("flush_again_2", M_FL | M_PC | M_PV, 6'b0, 6'b000110, 32'h600, 1, 0, 8'd0, 0);
        tick;
        chk("flush_again_done", M_FL | M_PC | M_PV, 6'b0, 6'b0, 32'h600, 0, 0, 8'd0, 0);
        tick;

        // Asynchronous reset in the middle of a drain with a redirect pending
        bus.halt_req_i = 1'b1;
        tick;
        chk("pre_reset_drain", M_ST | M_HA, 6'b000011, 6'b0, 32'h0, 0, 0, 8'd0, 0);
        tick;
        bus.flush_req_i = 1'b1;
        bus.flush_pc_i  = 32'h0000_0700;
        bus.stallreq_i  = 6'b001000;
        #1 rst = 1'b0;
        chk("reset_async", M_ALL, 6'b0, 6'b0, 32'h0, 0, 0, 8'd0, 0);
        tick;
        bus.flush_req_i = 1'b0;
        bus.halt_req_i  = 1'b0;
        bus.stallreq_i  = 6'b0;
        rst = 1'b1;
        chk("post_reset", M_ALL, 6'b0, 6'b0, 32'h0, 0, 0, 8'd0, 0);
        tick;
        chk("post_reset2", M_ALL, 6'b0, 6'b0, 32'h0, 0, 0, 8'd0, 0);
        tick;
        tick;

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
